// File: rtl/decode_stage.sv
// decode_stage -- RV32I instruction-decode stage.
//
// Decodes OP-IMM and OP instructions from fetch and registers the result
// into id_ex_r together with the rs1/rs2 operand values. It owns the 32-entry
// register file, which is written from the writeback port. A busy-bit
// scoreboard holds fetch off on RAW and WAW hazards against instructions
// that are still in flight.
//
// Ports:
//   clk, reset_n          clock; asynchronous active-low reset
//   if_valid / if_instr   fetched instruction and its valid flag
//   if_ready              decode accepts this cycle (combinational, !stall)
//   flush                 discard the instruction presented this cycle
//   wb_en/wb_addr/wb_data writeback port into the register file
//   id_ex_r               decoded packet for the ALU stage
//   alu_reg_input_a/b     rs1 / rs2 values, registered alongside id_ex_r
//   illegal_instr         one-cycle pulse when an unsupported encoding issues

package decode_pkg;

  typedef enum logic [4:0] {
    ALU_NONE = 5'd0,
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_ADDI, ALU_SLTI, ALU_SLTIU, ALU_XORI, ALU_ORI,
    ALU_ANDI, ALU_SLLI, ALU_SRLI, ALU_SRAI
  } alu_op_e;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [4:0]  shamt;
    logic [31:0] inst_imm_sgn;
    logic [4:0]  reg_wr_addr;
    logic        rd_wr_en;
    logic        do_not_execute;
  } ID_EX;

  localparam ID_EX ID_EX_BUBBLE = '{
    alu_op:         ALU_NONE,
    shamt:          5'd0,
    inst_imm_sgn:   32'd0,
    reg_wr_addr:    5'd0,
    rd_wr_en:       1'b0,
    do_not_execute: 1'b1
  };

endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  output logic            if_ready,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output ID_EX            id_ex_r,
  output logic [XLEN-1:0] alu_reg_input_a,
  output logic [XLEN-1:0] alu_reg_input_b,
  output logic            illegal_instr
);

  localparam logic [6:0]       OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]       OPC_OP     = 7'b0110011;
  localparam logic [6:0]       F7_BASE    = 7'b0000000;
  localparam logic [6:0]       F7_ALT     = 7'b0100000;
  localparam logic [NREGS-1:0] ONE_HOT0   = {{(NREGS-1){1'b0}}, 1'b1};

  logic [6:0]       opcode_p0;
  logic [6:0]       funct7_p0;
  logic [2:0]       funct3_p0;
  logic [4:0]       rs1_p0;
  logic [4:0]       rs2_p0;
  logic [4:0]       rd_p0;
  alu_op_e          op_p0;
  logic             is_op_p0;
  logic             legal_p0;
  logic             wr_rd_p0;
  logic             stall_p0;
  logic             issue_p0;
  logic             wb_wr;
  ID_EX             pkt_p0;
  logic [XLEN-1:0]  rs1_val_p0;
  logic [XLEN-1:0]  rs2_val_p0;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] eff_busy;
  logic [NREGS-1:0] busy_nxt;
  logic [XLEN-1:0]  rf [NREGS];

  // ---- Stage p0: field extraction and opcode/funct decode ----
  assign opcode_p0 = if_instr[6:0];
  assign rd_p0     = if_instr[11:7];
  assign funct3_p0 = if_instr[14:12];
  assign rs1_p0    = if_instr[19:15];
  assign rs2_p0    = if_instr[24:20];
  assign funct7_p0 = if_instr[31:25];

  always_comb begin
    op_p0    = ALU_NONE;
    is_op_p0 = 1'b0;
    if (opcode_p0 == OPC_OP_IMM) begin
      case (funct3_p0)
        3'b000: op_p0 = ALU_ADDI;
        3'b001: if (funct7_p0 == F7_BASE) op_p0 = ALU_SLLI;
        3'b010: op_p0 = ALU_SLTI;
        3'b011: op_p0 = ALU_SLTIU;
        3'b100: op_p0 = ALU_XORI;
        3'b101: begin
          if (funct7_p0 == F7_BASE)     op_p0 = ALU_SRLI;
          else if (funct7_p0 == F7_ALT) op_p0 = ALU_SRAI;
        end
        3'b110: op_p0 = ALU_ORI;
        3'b111: op_p0 = ALU_ANDI;
      endcase
    end else if (opcode_p0 == OPC_OP) begin
      is_op_p0 = 1'b1;
      if (funct7_p0 == F7_BASE) begin
        case (funct3_p0)
          3'b000: op_p0 = ALU_ADD;
          3'b001: op_p0 = ALU_SLL;
          3'b010: op_p0 = ALU_SLT;
          3'b011: op_p0 = ALU_SLTU;
          3'b100: op_p0 = ALU_XOR;
          3'b101: op_p0 = ALU_SRL;
          3'b110: op_p0 = ALU_OR;
          3'b111: op_p0 = ALU_AND;
        endcase
      end else if (funct7_p0 == F7_ALT) begin
        if (funct3_p0 == 3'b000)      op_p0 = ALU_SUB;
        else if (funct3_p0 == 3'b101) op_p0 = ALU_SRA;
      end
    end
  end

  // Every legal encoding maps to a real ALU op, so ALU_NONE marks illegal.
  assign legal_p0 = (op_p0 != ALU_NONE);
  assign wr_rd_p0 = legal_p0 && (rd_p0 != 5'd0);

  always_comb begin
    pkt_p0                = ID_EX_BUBBLE;
    pkt_p0.alu_op         = op_p0;
    pkt_p0.shamt          = if_instr[24:20];
    pkt_p0.inst_imm_sgn   = {{20{if_instr[31]}}, if_instr[31:20]};
    pkt_p0.reg_wr_addr    = rd_p0;
    pkt_p0.rd_wr_en       = wr_rd_p0;
    pkt_p0.do_not_execute = 1'b0;
  end

  // ---- Stage p0: scoreboard and handshake ----
  // A writeback landing this cycle already releases its register, so an
  // instruction waiting on it can issue in the same cycle.
  assign wb_wr    = wb_en && (wb_addr != 5'd0);
  assign clr_vec  = wb_wr ? (ONE_HOT0 << wb_addr) : '0;
  assign eff_busy = busy & ~clr_vec;

  // Illegal encodings never stall: they issue as a bubble straight away.
  assign stall_p0 = if_valid && legal_p0 &&
                    (eff_busy[rs1_p0] ||
                     (is_op_p0 && eff_busy[rs2_p0]) ||
                     (wr_rd_p0 && eff_busy[rd_p0]));

  assign if_ready = !stall_p0;
  assign issue_p0 = if_valid && if_ready && !flush;

  // Set is OR-ed after the clear so a same-register set/clear keeps the bit.
  assign set_vec  = (issue_p0 && wr_rd_p0) ? (ONE_HOT0 << rd_p0) : '0;
  assign busy_nxt = (eff_busy | set_vec) & ~ONE_HOT0;

  // ---- Stage p0: register file read with write-through bypass ----
  assign rs1_val_p0 = (rs1_p0 == 5'd0)              ? '0      :
                      (wb_wr && wb_addr == rs1_p0)  ? wb_data :
                                                      rf[rs1_p0];
  assign rs2_val_p0 = (rs2_p0 == 5'd0)              ? '0      :
                      (wb_wr && wb_addr == rs2_p0)  ? wb_data :
                                                      rf[rs2_p0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_wr) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // ---- Stage p0 -> p1 boundary: ID/EX register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy            <= '0;
      id_ex_r         <= ID_EX_BUBBLE;
      alu_reg_input_a <= '0;
      alu_reg_input_b <= '0;
      illegal_instr   <= 1'b0;
    end else begin
      busy          <= busy_nxt;
      illegal_instr <= issue_p0 && !legal_p0;
      if (issue_p0 && legal_p0) begin
        id_ex_r         <= pkt_p0;
        alu_reg_input_a <= rs1_val_p0;
        alu_reg_input_b <= is_op_p0 ? rs2_val_p0 : '0;
      end else begin
        id_ex_r         <= ID_EX_BUBBLE;
        alu_reg_input_a <= '0;
        alu_reg_input_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = 32'd0;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        if_ready;
  ID_EX        id_ex_r;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        illegal_instr;

  int n_run  = 0;
  int n_fail = 0;

  decode_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .flush          (flush),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .id_ex_r        (id_ex_r),
    .alu_reg_input_a(alu_a),
    .alu_reg_input_b(alu_b),
    .illegal_instr  (illegal_instr)
  );

  always #5 clk = ~clk;

  // Reference encoding table: one row per legal instruction.
  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         f7_care;
    alu_op_e    op;
  } enc_t;
  enc_t tbl[$];

  logic [31:0] m_busy;
  logic [31:0] m_rf [32];

  function automatic enc_t mk(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7, bit care, alu_op_e op);
    enc_t e;
    e.opc = opc; e.f3 = f3; e.f7 = f7; e.f7_care = care; e.op = op;
    return e;
  endfunction

  task automatic build_table();
    logic [6:0] oi, orr, z, a;
    oi = 7'h13; orr = 7'h33; z = 7'h00; a = 7'h20;
    tbl.push_back(mk(oi, 3'd0, z, 1'b0, ALU_ADDI));
    tbl.push_back(mk(oi, 3'd2, z, 1'b0, ALU_SLTI));
    tbl.push_back(mk(oi, 3'd3, z, 1'b0, ALU_SLTIU));
    tbl.push_back(mk(oi, 3'd4, z, 1'b0, ALU_XORI));
    tbl.push_back(mk(oi, 3'd6, z, 1'b0, ALU_ORI));
    tbl.push_back(mk(oi, 3'd7, z, 1'b0, ALU_ANDI));
    tbl.push_back(mk(oi, 3'd1, z, 1'b1, ALU_SLLI));
    tbl.push_back(mk(oi, 3'd5, z, 1'b1, ALU_SRLI));
    tbl.push_back(mk(oi, 3'd5, a, 1'b1, ALU_SRAI));
    tbl.push_back(mk(orr, 3'd0, z, 1'b1, ALU_ADD));
    tbl.push_back(mk(orr, 3'd1, z, 1'b1, ALU_SLL));
    tbl.push_back(mk(orr, 3'd2, z, 1'b1, ALU_SLT));
    tbl.push_back(mk(orr, 3'd3, z, 1'b1, ALU_SLTU));
    tbl.push_back(mk(orr, 3'd4, z, 1'b1, ALU_XOR));
    tbl.push_back(mk(orr, 3'd5, z, 1'b1, ALU_SRL));
    tbl.push_back(mk(orr, 3'd6, z, 1'b1, ALU_OR));
    tbl.push_back(mk(orr, 3'd7, z, 1'b1, ALU_AND));
    tbl.push_back(mk(orr, 3'd0, a, 1'b1, ALU_SUB));
    tbl.push_back(mk(orr, 3'd5, a, 1'b1, ALU_SRA));
  endtask

  function automatic ID_EX bubble();
    ID_EX e;
    e = '0;
    e.alu_op = ALU_NONE;
    e.do_not_execute = 1'b1;
    return e;
  endfunction

  function automatic ID_EX pkt(alu_op_e op, logic [31:0] ins);
    ID_EX e;
    e.alu_op = op;
    e.shamt = ins[24:20];
    e.inst_imm_sgn = {{20{ins[31]}}, ins[31:20]};
    e.reg_wr_addr = ins[11:7];
    e.rd_wr_en = (ins[11:7] != 5'd0);
    e.do_not_execute = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; if_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_run++; if (id_ex_r !== bubble()) begin n_fail++; $display("FAIL reset_pkt got %h want %h", id_ex_r, bubble()); end
    n_run++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin n_fail++; $display("FAIL reset_ops got %h/%h want 0/0", alu_a, alu_b); end
    n_run++; if (illegal_instr !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", illegal_instr); end
    n_run++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", if_ready); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_addi();
    if_valid = 1'b1; if_instr = 32'h00500093;
    #1;
    n_run++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL addi_ready got %b want 1", if_ready); end
    @(posedge clk); #1;
    n_run++; if (id_ex_r !== pkt(ALU_ADDI, 32'h00500093)) begin n_fail++; $display("FAIL addi_pkt got %h want %h", id_ex_r, pkt(ALU_ADDI, 32'h00500093)); end
    n_run++; if (id_ex_r.inst_imm_sgn !== 32'd5 || id_ex_r.reg_wr_addr !== 5'd1) begin n_fail++; $display("FAIL addi_fields got imm %h rd %0d want 5/1", id_ex_r.inst_imm_sgn, id_ex_r.reg_wr_addr); end
    @(negedge clk); if_valid = 1'b0;
  endtask

  task automatic test_raw_stall();
    if_valid = 1'b1; if_instr = 32'h00108133;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_run++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL raw_ready cyc %0d got %b want 0", i, if_ready); end
      @(posedge clk); #1;
      n_run++; if (id_ex_r !== bubble()) begin n_fail++; $display("FAIL raw_bubble cyc %0d got %h want %h", i, id_ex_r, bubble()); end
      @(negedge clk);
    end
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
    #1;
    n_run++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release got %b want 1", if_ready); end
    @(posedge clk); #1;
    n_run++; if (id_ex_r !== pkt(ALU_ADD, 32'h00108133)) begin n_fail++; $display("FAIL raw_pkt got %h want %h", id_ex_r, pkt(ALU_ADD, 32'h00108133)); end
    n_run++; if (alu_a !== 32'd5 || alu_b !== 32'd5) begin n_fail++; $display("FAIL raw_ops got %h/%h want 5/5", alu_a, alu_b); end
    @(negedge clk); if_valid = 1'b0; wb_en = 1'b0;
  endtask

  task automatic test_srai();
    logic [31:0] ins;
    if_valid = 1'b1; if_instr = 32'h4040D193;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h80000000;
    #1;
    n_run++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL srai_ready got %b want 1", if_ready); end
    @(posedge clk); #1;
    n_run++; if (id_ex_r !== pkt(ALU_SRAI, 32'h4040D193) || id_ex_r.shamt !== 5'd4) begin n_fail++; $display("FAIL srai_pkt got %h want %h", id_ex_r, pkt(ALU_SRAI, 32'h4040D193)); end
    n_run++; if (alu_a !== 32'h80000000 || alu_b !== 32'd0) begin n_fail++; $display("FAIL srai_ops got %h/%h want 80000000/0", alu_a, alu_b); end
    @(negedge clk); if_valid = 1'b0; wb_addr = 5'd2; wb_data = 32'h11;
    @(negedge clk); wb_addr = 5'd3; wb_data = 32'h22;
    @(negedge clk); wb_en = 1'b0;
    ins = enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd5);
    if_valid = 1'b1; if_instr = ins;
    #1;
    n_run++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL rf_ready got %b want 1", if_ready); end
    @(posedge clk); #1;
    n_run++; if (alu_a !== 32'h80000000 || alu_b !== 32'h80000000) begin n_fail++; $display("FAIL rf_read got %h/%h want 80000000/80000000", alu_a, alu_b); end
    @(negedge clk); if_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0;
    @(negedge clk); wb_en = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] ins;
    if_valid = 1'b1; if_instr = enc_i(12'd1, 5'd0, 3'd0, 5'd7);
    @(negedge clk);
    ins = enc_r(7'b0000001, 5'd7, 5'd7, 3'd0, 5'd6);
    if_instr = ins;
    #1;
    n_run++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready got %b want 1", if_ready); end
    @(posedge clk); #1;
    n_run++; if (id_ex_r !== bubble()) begin n_fail++; $display("FAIL ill_pkt got %h want %h", id_ex_r, bubble()); end
    n_run++; if (illegal_instr !== 1'b1) begin n_fail++; $display("FAIL ill_pulse got %b want 1", illegal_instr); end
    @(negedge clk); if_instr = 32'h00000073;
    #1;
    n_run++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL ecall_ready got %b want 1", if_ready); end
    @(posedge clk); #1;
    n_run++; if (illegal_instr !== 1'b1 || id_ex_r !== bubble()) begin n_fail++; $display("FAIL ecall_pulse got %b %h want 1 %h", illegal_instr, id_ex_r, bubble()); end
    @(negedge clk); if_valid = 1'b0;
    @(posedge clk); #1;
    n_run++; if (illegal_instr !== 1'b0) begin n_fail++; $display("FAIL ill_once got %b want 0", illegal_instr); end
    @(negedge clk); if_valid = 1'b1; if_instr = enc_r(7'd0, 5'd6, 5'd6, 3'd0, 5'd8);
    #1;
    n_run++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL ill_nobusy got %b want 1", if_ready); end
    @(negedge clk); if_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h7;
    @(negedge clk); wb_addr = 5'd8;
    @(negedge clk); wb_en = 1'b0;
  endtask

  task automatic test_x0();
    if_valid = 1'b1; if_instr = 32'h00100013;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    #1;
    n_run++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got %b want 1", if_ready); end
    @(posedge clk); #1;
    n_run++; if (id_ex_r !== pkt(ALU_ADDI, 32'h00100013) || id_ex_r.rd_wr_en !== 1'b0) begin n_fail++; $display("FAIL x0_pkt got %h want %h", id_ex_r, pkt(ALU_ADDI, 32'h00100013)); end
    n_run++; if (alu_a !== 32'd0) begin n_fail++; $display("FAIL x0_bypass got %h want 0", alu_a); end
    @(negedge clk); wb_en = 1'b0; if_instr = enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd9);
    #1;
    n_run++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL x0_notbusy got %b want 1", if_ready); end
    @(posedge clk); #1;
    n_run++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin n_fail++; $display("FAIL x0_read got %h/%h want 0/0", alu_a, alu_b); end
    @(negedge clk); if_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h9;
    @(negedge clk); wb_en = 1'b0;
  endtask

  task automatic test_flush();
    if_valid = 1'b1; flush = 1'b1; if_instr = enc_i(12'd1, 5'd0, 3'd0, 5'd4);
    @(posedge clk); #1;
    n_run++; if (id_ex_r !== bubble() || illegal_instr !== 1'b0) begin n_fail++; $display("FAIL flush_bubble got %h want %h", id_ex_r, bubble()); end
    @(negedge clk); flush = 1'b0; if_instr = enc_r(7'd0, 5'd4, 5'd4, 3'd0, 5'd10);
    #1;
    n_run++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL flush_noset got %b want 1", if_ready); end
    @(negedge clk); flush = 1'b1; if_instr = enc_i(12'd1, 5'd0, 3'd0, 5'd4);
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hCAFE0001;
    @(negedge clk); flush = 1'b0; wb_en = 1'b0; if_instr = enc_r(7'd0, 5'd0, 5'd10, 3'd0, 5'd11);
    #1;
    n_run++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL flush_clr got %b want 1", if_ready); end
    @(posedge clk); #1;
    n_run++; if (alu_a !== 32'hCAFE0001) begin n_fail++; $display("FAIL flush_wb got %h want cafe0001", alu_a); end
    @(negedge clk); if_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd11;
    @(negedge clk); wb_en = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    if_valid = 1'b1; if_instr = enc_i(12'd3, 5'd0, 3'd0, 5'd12);
    @(negedge clk); if_instr = enc_r(7'd0, 5'd1, 5'd12, 3'd0, 5'd13);
    #1;
    n_run++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", if_ready); end
    #2 reset_n = 1'b0;
    #1;
    n_run++; if (id_ex_r !== bubble()) begin n_fail++; $display("FAIL rst_async_pkt got %h want %h", id_ex_r, bubble()); end
    n_run++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL rst_busy_clear got %b want 1", if_ready); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    n_run++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin n_fail++; $display("FAIL rst_rf got %h/%h want 0/0", alu_a, alu_b); end
    @(negedge clk); if_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] ins, eff, exp_a, exp_b;
    logic [4:0]  rs1, rs2, rd;
    logic        legal, is_op, wr, stall, acc, clr, last_stall;
    alu_op_e     op;
    ID_EX        exp_pkt;
    enc_t        e;
    logic [4:0]  bq[$];
    reset_n = 1'b0; if_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
    m_busy = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    @(negedge clk); reset_n = 1'b1;
    last_stall = 1'b0; ins = 32'd0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if_valid = ($urandom_range(3) != 0);
      flush = ($urandom_range(9) == 0);
      if (!(last_stall && $urandom_range(3) != 0)) begin
        if ($urandom_range(7) == 0) ins = $urandom;
        else begin
          e = tbl[$urandom_range(tbl.size() - 1)];
          ins = {e.f7_care ? e.f7 : 7'($urandom), 5'($urandom_range(7)), 5'($urandom_range(7)), e.f3, 5'($urandom_range(7)), e.opc};
        end
      end
      if_instr = ins;
      bq.delete();
      for (int r = 1; r < 32; r++) if (m_busy[r]) bq.push_back(5'(r));
      wb_en = $urandom_range(1);
      if (bq.size() != 0 && $urandom_range(1) != 0) wb_addr = bq[$urandom_range(bq.size() - 1)];
      else wb_addr = 5'($urandom_range(7));
      wb_data = $urandom;
      #1;
      clr = wb_en && (wb_addr != 5'd0);
      eff = m_busy;
      if (clr) eff[wb_addr] = 1'b0;
      legal = 1'b0; op = ALU_NONE; is_op = (ins[6:0] == 7'h33);
      foreach (tbl[k])
        if (tbl[k].opc == ins[6:0] && tbl[k].f3 == ins[14:12] && (!tbl[k].f7_care || tbl[k].f7 == ins[31:25])) begin
          legal = 1'b1; op = tbl[k].op;
        end
      rs1 = ins[19:15]; rs2 = ins[24:20]; rd = ins[11:7];
      wr = legal && (rd != 5'd0);
      stall = if_valid && legal && (eff[rs1] || (is_op && eff[rs2]) || (wr && eff[rd]));
      n_run++; if (if_ready !== !stall) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, if_ready, !stall); end
      acc = if_valid && !stall && !flush;
      exp_pkt = (acc && legal) ? pkt(op, ins) : bubble();
      exp_a = (rs1 == 5'd0) ? 32'd0 : (clr && wb_addr == rs1) ? wb_data : m_rf[rs1];
      exp_b = !is_op ? 32'd0 : (rs2 == 5'd0) ? 32'd0 : (clr && wb_addr == rs2) ? wb_data : m_rf[rs2];
      @(posedge clk); #1;
      n_run++; if (id_ex_r !== exp_pkt) begin n_fail++; $display("FAIL rnd_pkt cyc %0d ins %h got %h want %h", cyc, ins, id_ex_r, exp_pkt); end
      n_run++; if (illegal_instr !== (acc && !legal)) begin n_fail++; $display("FAIL rnd_illegal cyc %0d got %b want %b", cyc, illegal_instr, acc && !legal); end
      if (acc && legal) begin
        n_run++; if (alu_a !== exp_a || alu_b !== exp_b) begin n_fail++; $display("FAIL rnd_ops cyc %0d got %h/%h want %h/%h", cyc, alu_a, alu_b, exp_a, exp_b); end
      end
      if (clr) m_rf[wb_addr] = wb_data;
      m_busy = eff;
      if (acc && wr) m_busy[rd] = 1'b1;
      last_stall = stall;
    end
    @(negedge clk); if_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    build_table();
    test_reset();
    test_addi();
    test_raw_stall();
    test_srai();
    test_illegal();
    test_x0();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage for the RV32I integer pipeline; sits directly upstream of the ALU stage and produces its `id_ex_r` register plus the operand values `alu_reg_input_a` / `alu_reg_input_b`.
- Accepts fetched instructions over a valid/ready handshake and decodes OP-IMM (0010011) and OP (0110011).
- Owns the 32x32 register file, which is written from the writeback port.
- Keeps a busy-bit scoreboard and stalls fetch on read-after-write (RAW) and write-after-write (WAW) hazards against in-flight instructions.

Parameters:
- `XLEN`, 32, datapath and register width.
- `NREGS`, 32, architectural register count (x0 hardwired to zero).

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `if_valid`  in  1  fetch presents an instruction.
- `if_instr`  in  32  instruction word.
- `if_ready`  out  1  decode accepts this cycle.
- `flush`  in  1  discard the instruction presented this cycle.
- `wb_en`  in  1  writeback write enable.
- `wb_addr`  in  5  writeback destination register.
- `wb_data`  in  32  writeback value.
- `id_ex_r`  out  ID_EX  decoded packet: `alu_op`, `shamt`, `inst_imm_sgn`, `reg_wr_addr`, `rd_wr_en`, `do_not_execute`.
- `alu_reg_input_a`  out  32  rs1 value, registered with `id_ex_r`.
- `alu_reg_input_b`  out  32  rs2 value, registered with `id_ex_r`.
- `illegal_instr`  out  1  one-cycle pulse when an unsupported encoding is accepted.

Behaviour:
- Reset (async, immediate):
  - All registers 0.
  - Scoreboard cleared.
  - `id_ex_r` is a bubble: `alu_op`=ALU_NONE, `do_not_execute`=1, `rd_wr_en`=0, other fields 0.
  - Operand outputs 0; `illegal_instr`=0.
  - Reset mid-stall drops the pending instruction.
- Handshake:
  - Issue occurs when `if_valid` && `if_ready` && !`flush`.
  - `if_ready` = !`stall`, combinational.
  - Latency 1: the issued packet appears on `id_ex_r` and the operand outputs after the accepting edge.
  - Every cycle without an issue loads a bubble.
- Decode:
  - rs1 = [19:15], rs2 = [24:20], rd = [11:7].
  - `inst_imm_sgn` = sign-extended [31:20].
  - `shamt` = [24:20].
  - OP-IMM, by funct3:
    - 000 ADDI; 010 SLTI; 011 SLTIU; 100 XORI; 110 ORI; 111 ANDI.
    - 001 SLLI, only with funct7 = 0000000.
    - 101 SRLI with funct7 = 0000000; SRAI with funct7 = 0100000.
  - OP:
    - funct7 = 0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
    - funct7 = 0100000: SUB (funct3 000) and SRA (funct3 101).
  - Any other opcode/funct combination is illegal:
    - Issued as `alu_op`=ALU_NONE, `do_not_execute`=1, `rd_wr_en`=0.
    - `illegal_instr` pulses 1 cycle; no stall check applies.
  - `rd_wr_en` = 1 for legal instructions with rd != 0; `reg_wr_addr` = rd.
- Hazard check (scoreboard `busy[31:0]`, busy[0] always 0):
  - `clr` = `wb_en` && `wb_addr` != 0 clears busy[`wb_addr`].
  - `eff_busy` = busy & ~(`clr` one-hot).
  - `stall` is asserted when `if_valid`, the instruction is legal, and any of:
    - `eff_busy`[rs1];
    - OP && `eff_busy`[rs2];
    - `rd_wr_en` && `eff_busy`[rd].
  - An issue with `rd_wr_en` sets busy[rd].
  - If set and clear hit the same register in the same cycle, set wins.
- Register file:
  - Written on `wb_en` with `wb_addr` != 0; writes to x0 are ignored.
  - Reads of x0 return 0.
  - Write-through bypass: a read of the register being written in the same cycle returns `wb_data`.
  - For OP-IMM, `alu_reg_input_b` = 0.
- Flush:
  - Forces a bubble and `if_ready` is don't-care.
  - Does not alter the scoreboard; in-flight writebacks still clear their bits.
- `wb_en` with a register that is not busy: write still performed; scoreboard unchanged.

Test Plan:
- Reset, then `if_instr`=0x00500093 (addi x1,x0,5) valid 1 cycle:
  - Next cycle `alu_op`=ALU_ADDI, `inst_imm_sgn`=5, `reg_wr_addr`=1, `rd_wr_en`=1, `do_not_execute`=0.
  - busy[1]=1.
- Then 0x00108133 (add x2,x1,x1) held valid with no writeback:
  - `if_ready`=0, bubbles issued.
  - When `wb_en`=1, `wb_addr`=1, `wb_data`=5: accepted that cycle; next cycle `alu_op`=ALU_ADD, operands a=5, b=5.
- With x1=0x80000000, issue 0x4040D193 (srai x3,x1,4):
  - `alu_op`=ALU_SRAI, `shamt`=4, `alu_reg_input_a`=0x80000000, `alu_reg_input_b`=0.
- `if_instr`=0x00000073 (ecall):
  - `illegal_instr` pulses once; bubble-equivalent packet; scoreboard unchanged.
  - `if_ready` stays 1.
- addi x0,x0,1 (0x00100013):
  - `rd_wr_en`=0; busy unchanged.
  - `wb_en` to x0 with 0xFFFFFFFF: a subsequent read of x0 returns 0.
- `flush`=1 with a valid addi x4:
  - Bubble output; busy[4] stays 0.
  - Assert `reset_n`=0 mid-stall: `id_ex_r` is an immediate bubble and busy = 0.
